// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter: round-robin arbiter sharing one odd-parity checker
// between NUM_REQ requesters, with a tagged verdict channel and saturating error counter.
module parity_check_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 3,
    parameter int ERR_W   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_par,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_err,
    output logic [ERR_W-1:0]          err_count,
    input  logic                      clr_cnt
);
    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      grant_q, grant_d, last_q, last_d, pick;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                par_q, par_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [ERR_W-1:0]    cnt_q, cnt_d;
    logic                found, hs;

    // Search upward from the requester after the last one served, wrapping around.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                pick  = IDW'((int'(last_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign hs = rsp_valid_q & rsp_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        data_d      = data_q;
        par_d       = par_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (req_valid[grant_q]) begin
                    data_d  = req_data[int'(grant_q)*DATA_W +: DATA_W];
                    par_d   = req_par[grant_q];
                    last_d  = grant_q;
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                rsp_err_d   = ~(^data_q ^ par_q);
                rsp_id_d    = grant_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear in the same cycle as an erroneous handshake wins.
        cnt_d = clr_cnt ? '0 : (hs && rsp_err_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IDW'(NUM_REQ - 1);
            data_q      <= '0;
            par_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            data_q      <= data_d;
            par_q       <= par_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == CAPTURE) ? NUM_REQ'(1) << grant_q : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = cnt_q;
endmodule

// File: tb/tb_parity_check_arbiter.sv
// tb_parity_check_arbiter: random and directed stimulus against a transaction-level
// model of the shared parity checker, plus literal expectations for key scenarios.
module tb_parity_check_arbiter;
    localparam int N = 4, DW = 3, EW = 8, IDW = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0]    req_valid = '0, req_par = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            rsp_valid, rsp_ready = 1'b1, rsp_err, clr_cnt = 1'b0;
    logic [IDW-1:0]  rsp_id;
    logic [EW-1:0]   err_count;

    int checks = 0, errors = 0;
    bit en = 1'b0, hold_all = 1'b0;

    // Model: m_grant < 0 means no requester owns the checker; m_age counts cycles since grant.
    int m_grant = -1, m_age = 0, m_last = N-1, m_cnt = 0, m_rid = 0, m_acc = -1;
    bit m_rv = 0, m_rerr = 0, m_pend = 0;

    always #5 clk = ~clk;

    parity_check_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_par(req_par), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .err_count(err_count), .clr_cnt(clr_cnt)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task model_step();
        m_acc = -1;
        if (rst) begin
            m_grant = -1; m_age = 0; m_last = N-1; m_cnt = 0;
            m_rv = 0; m_rid = 0; m_rerr = 0;
            return;
        end
        if (clr_cnt) m_cnt = 0;
        else if (m_rv && rsp_ready && m_rerr) m_cnt = (m_cnt + 1 > 2**EW - 1) ? 2**EW - 1 : m_cnt + 1;
        if (m_grant < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_grant < 0 && req_valid[(m_last + k) % N]) m_grant = (m_last + k) % N;
            m_age = 1;
        end else if (m_age == 1) begin
            if (req_valid[m_grant]) begin
                m_acc  = m_grant;
                m_last = m_grant;
                m_pend = ($countones({req_data[m_grant*DW +: DW], req_par[m_grant]}) % 2) == 0;
                m_age  = 2;
            end else begin
                m_grant = -1;
            end
        end else if (m_age == 2) begin
            m_rv = 1; m_rid = m_grant; m_rerr = m_pend; m_age = 3;
        end else if (rsp_ready) begin
            m_rv = 0; m_grant = -1;
        end
    endtask

    task tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_acc >= 0 && !hold_all) req_valid[m_acc] = 1'b0;
    endtask

    task do_reset();
        rst = 1'b1; req_valid = '0; clr_cnt = 1'b0; rsp_ready = 1'b1; hold_all = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("req_ready", req_ready, (m_grant >= 0 && m_age == 1) ? (1 << m_grant) : 0);
            chk("rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                chk("rsp_id", rsp_id, m_rid);
                chk("rsp_err", rsp_err, m_rerr);
            end
            chk("err_count", err_count, m_cnt);
        end
    end

    initial begin
        int q[$];
        int exp_a[6] = '{0, 1, 2, 3, 0, 1};
        int exp_b[4] = '{1, 3, 1, 3};
        do_reset();
        en = 1'b1;
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_err_count", err_count, 0);

        // Single good word on requester 0.
        req_valid[0] = 1'b1; req_data[0 +: DW] = 3'b100; req_par[0] = 1'b0;
        tick(); chk("good_ready", req_ready, 4'b0001);
        tick(); tick();
        chk("good_valid", rsp_valid, 1); chk("good_id", rsp_id, 0); chk("good_err", rsp_err, 0);
        tick(); chk("good_done", rsp_valid, 0); chk("good_cnt", err_count, 0);

        // Bad word then corrected parity on requester 2.
        req_valid[2] = 1'b1; req_data[2*DW +: DW] = 3'b110; req_par[2] = 1'b0;
        tick(); chk("bad_ready", req_ready, 4'b0100);
        tick(); tick();
        chk("bad_valid", rsp_valid, 1); chk("bad_id", rsp_id, 2); chk("bad_err", rsp_err, 1);
        tick(); chk("bad_cnt", err_count, 1);
        req_valid[2] = 1'b1; req_par[2] = 1'b1;
        tick(); tick(); tick();
        chk("fixed_err", rsp_err, 0);
        tick(); chk("fixed_cnt", err_count, 1);

        // Round-robin with all requesters continuously valid.
        do_reset();
        hold_all = 1'b1; req_valid = 4'b1111;
        for (int c = 0; c < 26; c++) begin
            tick();
            if ($countones(req_ready) == 1) q.push_back($clog2(req_ready));
        end
        chk("rr_all_count", q.size() >= 6, 1);
        for (int i = 0; i < 6; i++) chk("rr_all_order", i < q.size() ? q[i] : -1, exp_a[i]);
        do_reset();
        q.delete();
        hold_all = 1'b1; req_valid = 4'b1010;
        for (int c = 0; c < 18; c++) begin
            tick();
            if ($countones(req_ready) == 1) q.push_back($clog2(req_ready));
        end
        chk("rr_sub_count", q.size() >= 4, 1);
        for (int i = 0; i < 4; i++) chk("rr_sub_order", i < q.size() ? q[i] : -1, exp_b[i]);

        // Backpressure: response held while others wait.
        do_reset();
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1; req_data[0 +: DW] = 3'b011; req_par[0] = 1'b0;
        tick(); tick(); tick();
        req_valid[1] = 1'b1; req_valid[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", rsp_valid, 1); chk("bp_id", rsp_id, 0);
            chk("bp_err", rsp_err, 1); chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick(); chk("bp_release", rsp_valid, 0);
        tick(); chk("bp_next_grant", req_ready, 4'b0010);

        // Clear coinciding with an erroneous handshake.
        do_reset();
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1; req_data[0 +: DW] = 3'b011; req_par[0] = 1'b0;
        tick(); tick(); tick(); tick();
        rsp_ready = 1'b1; clr_cnt = 1'b1;
        tick(); clr_cnt = 1'b0;
        chk("clr_wins", err_count, 0);

        // Saturation at 2^EW-1.
        do_reset();
        for (int c = 0; c < 1100; c++) begin
            if (!req_valid[0]) begin
                req_valid[0] = 1'b1; req_data[0 +: DW] = 3'b110; req_par[0] = 1'b0;
            end
            tick();
        end
        chk("sat_cnt", err_count, 255);

        // Reset while the word is being checked.
        do_reset();
        req_valid[1] = 1'b1; req_data[DW +: DW] = 3'b000; req_par[1] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_mid_valid", rsp_valid, 0); chk("rst_mid_ready", req_ready, 0);
        tick(); tick(); tick();
        chk("rst_mid_never", rsp_valid, 0); chk("rst_mid_cnt", err_count, 0);

        // Granted requester withdraws during capture.
        do_reset();
        req_valid = 4'b0011;
        tick(); chk("viol_ready", req_ready, 4'b0001);
        req_valid[0] = 1'b0;
        tick(); chk("viol_idle", req_ready, 0); chk("viol_no_rsp", rsp_valid, 0);
        req_valid[0] = 1'b1;
        tick(); chk("viol_regrant", req_ready, 4'b0001);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                    req_par[i] = 1'($urandom);
                end else if ($urandom_range(60) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            clr_cnt   = ($urandom_range(40) == 0);
            rst       = ($urandom_range(400) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
